dmem_ctrl: RTL and testbench

//  Parametrised data-memory controller for the next-generation RISC-V core; replaces the fixed

---
 rtl/dmem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word storage, valid/ready request, programmable
// wait states, byte/half/word access and a registered response.
module dmem_ctrl #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 64,
    parameter int              WAIT_STATES = 1,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = XLEN / 8;
    localparam logic [XLEN:0] LIMIT = (XLEN+1)'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_d;
    logic [3:0] cnt, cnt_d;

    logic            a_write, a_uns;
    logic [1:0]      a_size;
    logic [XLEN-1:0] a_addr, a_wdata;

    logic            c_write, c_uns, c_err;
    logic [1:0]      c_size;
    logic [XLEN-1:0] c_addr, c_wdata;

    logic [XLEN-1:0] off, rword, sh, ld, wd;
    logic [NB-1:0]   be;
    logic [AW-1:0]   idx;
    logic            accept, commit, do_write, oob;

    logic [XLEN-1:0] mem [DEPTH];

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt <= 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the commit edge is the accept edge itself,
    // so the live request fields are used instead of the captured ones.
    always_comb begin
        if (state == IDLE) begin
            c_write = req_write;
            c_uns   = req_unsigned;
            c_size  = req_size;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end else begin
            c_write = a_write;
            c_uns   = a_uns;
            c_size  = a_size;
            c_addr  = a_addr;
            c_wdata = a_wdata;
        end
    end

    assign off      = c_addr - BASE_ADDR;
    assign oob      = (c_addr < BASE_ADDR) || ({1'b0, off} >= LIMIT);
    assign idx      = off[AW+1:2];
    assign commit   = (state_d == RESP);
    assign do_write = commit && c_write && !c_err;
    assign rword    = mem[idx];
    assign sh       = rword >> {off[1:0], 3'b000};

    always_comb begin
        c_err = oob;
        unique case (1'b1)
            c_size == 2'b00: c_err = oob;
            c_size == 2'b01: c_err = oob || c_addr[0];
            c_size == 2'b10: c_err = oob || (c_addr[1:0] != 2'b00);
            default:         c_err = 1'b1;
        endcase
    end

    always_comb begin
        ld = sh;
        unique case (1'b1)
            c_size == 2'b00:
                ld = c_uns ? {{(XLEN-8){1'b0}}, sh[7:0]}
                           : {{(XLEN-8){sh[7]}}, sh[7:0]};
            c_size == 2'b01:
                ld = c_uns ? {{(XLEN-16){1'b0}}, sh[15:0]}
                           : {{(XLEN-16){sh[15]}}, sh[15:0]};
            default: ld = sh;
        endcase
    end

    always_comb begin
        be = '1;
        wd = c_wdata;
        unique case (1'b1)
            c_size == 2'b00: begin
                be = NB'(1) << off[1:0];
                wd = {NB{c_wdata[7:0]}};
            end
            c_size == 2'b01: begin
                be = off[1] ? NB'(4'b1100) : NB'(4'b0011);
                wd = {(NB/2){c_wdata[15:0]}};
            end
            default: be = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (commit) begin
                rsp_rdata <= (c_write || c_err) ? '0 : ld;
                rsp_err   <= c_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_write <= req_write;
            a_uns   <= req_unsigned;
            a_size  <= req_size;
            a_addr  <= req_addr;
            a_wdata <= req_wdata;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one instance with one wait state and
// one with none, checked against a byte-addressed reference memory.
module tb_dmem_ctrl;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [1:0]  req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  rsp_valid, rsp_err;
    logic [1:0]  req_size  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];

    dmem_ctrl #(
        .XLEN(32), .DEPTH(DEPTH), .WAIT_STATES(1), .BASE_ADDR(32'h0)
    ) u_ws1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_ctrl #(
        .XLEN(32), .DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)
    ) u_ws0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] refm [2][4*DEPTH];
    int rsp_cnt [2];
    int last_acc [2];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference: little-endian, aligned accesses only.
    function automatic exp_t model(int d, logic w, logic [31:0] a,
                                   logic [1:0] sz, logic u,
                                   logic [31:0] wdat);
        exp_t e;
        int n;
        logic [31:0] v;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.acc   = 0;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3 || (a % n) != 0 || a >= 4 * DEPTH) begin
            e.err = 1'b1;
        end else if (w) begin
            for (int i = 0; i < n; i++) refm[d][a+i] = wdat[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = refm[d][a+i];
            if (!u && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!u && n == 2) v = {{16{v[15]}}, v[15:0]};
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic issue(input int d, input logic w, input logic [31:0] a,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] wdat, input bit track,
                         input bit usex, input logic [31:0] xr,
                         input logic xe);
        exp_t e;
        int t;
        req_valid[d]    = 1'b1;
        req_write[d]    = w;
        req_addr[d]     = a;
        req_size[d]     = sz;
        req_unsigned[d] = u;
        req_wdata[d]    = wdat;
        t = 0;
        @(negedge clk);
        while (!req_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[d]) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: dut %0d ready=0 required 1", d);
        end
        last_acc[d] = cyc;
        if (track) begin
            e = model(d, w, a, sz, u, wdat);
            if (usex) begin
                e.rdata = xr;
                e.err   = xe;
            end
            e.acc = cyc;
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic tr(input int d, input logic w, input logic [31:0] a,
                      input logic [1:0] sz, input logic u,
                      input logic [31:0] wdat);
        issue(d, w, a, sz, u, wdat, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic dx(input int d, input logic w, input logic [31:0] a,
                      input logic [1:0] sz, input logic u,
                      input logic [31:0] wdat, input logic [31:0] xr,
                      input logic xe);
        issue(d, w, a, sz, u, wdat, 1'b1, 1'b1, xr, xe);
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (rsp_valid[d]) begin
            rsp_cnt[d]++;
            check("ready_low_in_resp", {31'b0, req_ready[d]}, 32'h0);
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: dut %0d rsp_valid=1 required 0", d);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("rdata_dut%0d", d), rsp_rdata[d], e.rdata);
                check($sformatf("err_dut%0d", d), {31'b0, rsp_err[d]},
                      {31'b0, e.err});
                check($sformatf("latency_dut%0d", d), 32'(cyc - e.acc),
                      (d == 0) ? 32'd2 : 32'd1);
            end
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        mon(0);
        mon(1);
    end

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #2;
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d responses outstanding, required 0",
                     q0.size() + q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    initial begin
        int acc4 [4];
        int n0;
        logic [31:0] a;
        int r;

        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_unsigned = '0;
        rsp_cnt   = '{0, 0};
        last_acc  = '{0, 0};
        for (int d = 0; d < 2; d++) begin
            req_size[d]  = 2'd0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", {31'b0, req_ready[d]}, 32'h0);
            check("reset_rsp_valid", {31'b0, rsp_valid[d]}, 32'h0);
            check("reset_rdata", rsp_rdata[d], 32'h0);
            check("reset_err", {31'b0, rsp_err[d]}, 32'h0);
        end
        reset = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                tr(d, 1'b1, 32'(4*i), 2'd2, 1'b0, 32'hA500_0000 | 32'(i));
        drain();

        dx(0, 1'b1, 32'h8, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        dx(0, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);

        dx(0, 1'b1, 32'h9, 2'd0, 1'b0, 32'h80, 32'h0, 1'b0);
        dx(0, 1'b0, 32'h9, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0);
        dx(0, 1'b0, 32'h9, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 1'b0);
        dx(0, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 32'hDEAD_80EF, 1'b0);

        dx(0, 1'b1, 32'h3, 2'd1, 1'b0, 32'h1234, 32'h0, 1'b1);
        dx(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'hA500_0000, 1'b0);
        dx(0, 1'b0, 32'h4, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
        dx(0, 1'b1, 32'(4*DEPTH), 2'd2, 1'b0, 32'h1111_1111, 32'h0, 1'b1);
        dx(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'hA500_0000, 1'b0);
        drain();

        n0 = rsp_cnt[0];
        for (int i = 0; i < 4; i++) begin
            tr(0, 1'b1, 32'(32 + 4*i), 2'd2, 1'b0, 32'h5555_0000 + 32'(i));
            acc4[i] = last_acc[0];
        end
        for (int i = 1; i < 4; i++)
            check("accept_spacing_ws1", 32'(acc4[i] - acc4[i-1]), 32'd3);
        drain();
        check("pulse_count_ws1", 32'(rsp_cnt[0] - n0), 32'd4);

        n0 = rsp_cnt[0];
        issue(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hCAFE_F00D,
              1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        check("ready_in_reset", {31'b0, req_ready[0]}, 32'h0);
        @(posedge clk);
        #1;
        check("no_rsp_in_reset", {31'b0, rsp_valid[0]}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'b0, req_ready[0]}, 32'h1);
        repeat (3) @(posedge clk);
        #2;
        check("no_pulse_after_reset", 32'(rsp_cnt[0] - n0), 32'd0);
        dx(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hA500_0004, 1'b0);
        drain();

        dx(1, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 32'hA500_0002, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tr(1, 1'b0, 32'(4*i), 2'd2, 1'b0, 32'h0);
            acc4[i] = last_acc[1];
        end
        for (int i = 1; i < 4; i++)
            check("accept_spacing_ws0", 32'(acc4[i] - acc4[i-1]), 32'd2);
        drain();

        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 9);
            if (r < 8) a = 32'($urandom_range(0, 4*DEPTH - 1));
            else if (r == 8) a = 32'(4*DEPTH + $urandom_range(0, 7));
            else a = $urandom();
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            tr(k % 2, 1'($urandom_range(0, 1)), a,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom());
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
